// File: rtl/mcp3008_responder_pkg.sv
// rtl/mcp3008_responder_pkg.sv - shared encodings and sizes for the MCP3008 responder
package mcp3008_responder_pkg;

    localparam int MCP_DATA_W   = 10;
    localparam int MCP_NUM_CH   = 8;
    localparam int MCP_CMD_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CMD,
        ST_SAMPLE,
        ST_NULL,
        ST_MSB,
        ST_LSB,
        ST_TRAIL
    } mcp_state_t;

endpackage

// File: rtl/mcp3008_responder_if.sv
// rtl/mcp3008_responder_if.sv - SPI bus between the MCP3008 initiator and responder
interface mcp3008_if;
    logic dclk;
    logic cs_n;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output dclk, output cs_n, output din, input dout, input dout_oe);
    modport slave  (input dclk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/mcp3008_responder_sync_edge.sv
// rtl/mcp3008_responder_sync_edge.sv - N-stage synchronizer with rise/fall detection
module mcp3008_responder_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [N-1:0] r_sync;
    logic         r_prev;
    logic         w_q;

    // Resets high: the SPI clock idles high while the bus is deselected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {N{1'b1}};
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
            r_prev <= r_sync[N-1];
        end
    end

    assign w_q    = r_sync[N-1];
    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;
endmodule

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - oversampled SPI-slave emulation of an MCP3008 ADC
module mcp3008_responder
    import mcp3008_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = MCP_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    mcp3008_if.slave                       spi,
    input  logic [DATA_W*MCP_NUM_CH-1:0]   sample_data,
    output logic                           conv_done,
    output logic [2:0]                     conv_channel,
    output logic                           conv_sgl,
    output logic                           busy
);
    mcp_state_t                r_state;
    logic [SYNC_STAGES-1:0]    r_cs_sync;
    logic [SYNC_STAGES-1:0]    r_din_sync;
    logic [MCP_CMD_BITS-2:0]   r_cmd;
    logic [3:0]                r_bitcnt;
    logic [DATA_W-1:0]         r_shreg;
    logic                      r_dout;
    logic                      r_dout_oe;
    logic                      r_conv_done;
    logic [2:0]                r_conv_channel;
    logic                      r_conv_sgl;
    logic                      r_busy;
    logic                      r_armed;
    logic                      w_rise;
    logic                      w_fall;
    logic                      w_cs_n;
    logic                      w_din;

    mcp3008_responder_sync_edge #(.N(SYNC_STAGES)) u_dclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (spi.dclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync  <= {SYNC_STAGES{1'b1}};
            r_din_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs_n};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], spi.din};
        end
    end

    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_din  = r_din_sync[SYNC_STAGES-1];

    // r_armed blocks a frame that was already running when rst released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cmd          <= '0;
            r_bitcnt       <= '0;
            r_shreg        <= '0;
            r_dout         <= 1'b0;
            r_dout_oe      <= 1'b0;
            r_conv_done    <= 1'b0;
            r_conv_channel <= 3'd0;
            r_conv_sgl     <= 1'b0;
            r_busy         <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            r_busy      <= ~w_cs_n;
            if (w_cs_n) begin
                r_state   <= ST_IDLE;
                r_dout    <= 1'b0;
                r_dout_oe <= 1'b0;
                r_armed   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_armed) r_state <= ST_WAIT_START;
                    end
                    ST_WAIT_START: begin
                        if (w_rise && w_din) begin
                            r_state  <= ST_CMD;
                            r_bitcnt <= 4'd0;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_cmd    <= {r_cmd[MCP_CMD_BITS-3:0], w_din};
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'(MCP_CMD_BITS - 1)) begin
                                r_state        <= ST_SAMPLE;
                                r_conv_sgl     <= r_cmd[2];
                                r_conv_channel <= {r_cmd[1:0], w_din};
                            end
                        end
                    end
                    ST_SAMPLE: begin
                        if (w_fall) begin
                            r_shreg     <= sample_data[r_conv_channel*DATA_W +: DATA_W];
                            r_conv_done <= 1'b1;
                            r_state     <= ST_NULL;
                        end
                    end
                    ST_NULL: begin
                        if (w_fall) begin
                            r_dout_oe <= 1'b1;
                            r_dout    <= 1'b0;
                            r_bitcnt  <= 4'(DATA_W - 1);
                            r_state   <= ST_MSB;
                        end
                    end
                    ST_MSB: begin
                        if (w_fall) begin
                            r_dout <= r_shreg[r_bitcnt];
                            if (r_bitcnt == 4'd0) begin
                                r_bitcnt <= 4'd1;
                                r_state  <= ST_LSB;
                            end else begin
                                r_bitcnt <= r_bitcnt - 4'd1;
                            end
                        end
                    end
                    ST_LSB: begin
                        if (w_fall) begin
                            r_dout <= r_shreg[r_bitcnt];
                            if (r_bitcnt == 4'(DATA_W - 1)) r_state <= ST_TRAIL;
                            else                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    ST_TRAIL: begin
                        if (w_fall) r_dout <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi.dout     = r_dout;
    assign spi.dout_oe  = r_dout_oe;
    assign conv_done    = r_conv_done;
    assign conv_channel = r_conv_channel;
    assign conv_sgl     = r_conv_sgl;
    assign busy         = r_busy;
endmodule

// File: tb/tb_mcp3008_responder.sv
// tb/tb_mcp3008_responder.sv - scoreboard bench for the MCP3008 responder
module tb_mcp3008_responder;
    localparam int HALF = 8;

    logic        clk;
    logic        rst;
    logic [79:0] sample_data;
    logic        conv_done;
    logic [2:0]  conv_channel;
    logic        conv_sgl;
    logic        busy;
    logic        exp_q[$];
    int          total;
    int          bad;
    int          done_cnt;
    int          d0;

    mcp3008_if spi();

    mcp3008_responder #(.SYNC_STAGES(2), .DATA_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi.slave),
        .sample_data  (sample_data),
        .conv_done    (conv_done),
        .conv_channel (conv_channel),
        .conv_sgl     (conv_sgl),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [9:0] val, input int j);
        if (j >= 1 && j <= 10)       return val[10-j];
        else if (j >= 11 && j <= 19) return val[j-10];
        else                         return 1'b0;
    endfunction

    task automatic monitor();
        logic e;
        forever begin
            @(posedge spi.dclk);
            if (spi.dout_oe === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL dout_extra: got dout=%b with no bit expected", spi.dout);
                end else begin
                    e = exp_q.pop_front();
                    if (spi.dout !== e) begin
                        bad++;
                        $display("FAIL dout_bit: got %b expected %b", spi.dout, e);
                    end
                end
            end
        end
    endtask

    task automatic count_done();
        forever begin
            @(posedge clk);
            #1;
            if (conv_done === 1'b1) done_cnt++;
        end
    endtask

    // bits: leading zeros, start bit and command, MSB first in the low nbits
    task automatic frame(input logic [7:0] bits, input int nbits, input int ncyc,
                         input bit abort, input int rst_at, input bit swap,
                         input logic [9:0] val);
        bit dead;
        bit swapped;
        int j;
        dead    = 1'b0;
        swapped = 1'b0;
        spi.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < ncyc; i++) begin
            spi.dclk = 1'b0;
            spi.din  = (i < nbits) ? bits[nbits-1-i] : 1'b0;
            for (int k = 0; k < HALF; k++) begin
                @(negedge clk);
                if (swap && !swapped && conv_done === 1'b1) begin
                    @(negedge clk);
                    sample_data[29:20] = 10'h0FF;
                    swapped = 1'b1;
                end
            end
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_dout", {31'd0, spi.dout}, 32'd0);
                chk("rst_oe", {31'd0, spi.dout_oe}, 32'd0);
                chk("rst_done", {31'd0, conv_done}, 32'd0);
                chk("rst_chan", {29'd0, conv_channel}, 32'd0);
                chk("rst_sgl", {31'd0, conv_sgl}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
                rst  = 1'b0;
                dead = 1'b1;
            end
            if (abort && i == ncyc - 1) break;
            j = i - (nbits + 1);
            if (!dead && j >= 0) exp_q.push_back(exp_bit(val, j));
            spi.dclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (dead) chk("post_rst_oe", {31'd0, spi.dout_oe}, 32'd0);
        spi.cs_n = 1'b1;
        if (abort) begin
            repeat (3) @(posedge clk);
            #1;
            chk("abort_oe", {31'd0, spi.dout_oe}, 32'd0);
            spi.dclk = 1'b1;
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst      = 1'b1;
        spi.dclk = 1'b1;
        spi.cs_n = 1'b1;
        spi.din  = 1'b0;
        sample_data = '0;
        fork
            monitor();
            count_done();
        join_none
        repeat (3) @(negedge clk);
        chk("reset_dout", {31'd0, spi.dout}, 32'd0);
        chk("reset_oe", {31'd0, spi.dout_oe}, 32'd0);
        chk("reset_done", {31'd0, conv_done}, 32'd0);
        chk("reset_chan", {29'd0, conv_channel}, 32'd0);
        chk("reset_sgl", {31'd0, conv_sgl}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single-ended ch3 = 2A5
        sample_data[39:30] = 10'h2A5;
        d0 = done_cnt;
        frame(8'b11011, 5, 28, 1'b0, -1, 1'b0, 10'h2A5);
        chk("t1_chan", {29'd0, conv_channel}, 32'd3);
        chk("t1_sgl", {31'd0, conv_sgl}, 32'd1);
        chk("t1_done", done_cnt - d0, 32'd1);

        // 2: abort after the 12th fall, then ch0 = 3FF
        d0 = done_cnt;
        frame(8'b11011, 5, 12, 1'b1, -1, 1'b0, 10'h2A5);
        chk("t2_abort_done", done_cnt - d0, 32'd1);
        chk("t2_abort_busy", {31'd0, busy}, 32'd0);
        chk("t2_abort_q", exp_q.size(), 32'd0);
        sample_data[9:0] = 10'h3FF;
        d0 = done_cnt;
        frame(8'b11000, 5, 28, 1'b0, -1, 1'b0, 10'h3FF);
        chk("t2_chan", {29'd0, conv_channel}, 32'd0);
        chk("t2_done", done_cnt - d0, 32'd1);

        // 3: three leading zeros, ch7 = 001
        sample_data[79:70] = 10'h001;
        frame(8'b00011111, 8, 31, 1'b0, -1, 1'b0, 10'h001);
        chk("t3_chan", {29'd0, conv_channel}, 32'd7);
        chk("t3_sgl", {31'd0, conv_sgl}, 32'd1);

        // 4: differential ch5 = 155
        sample_data[59:50] = 10'h155;
        frame(8'b10101, 5, 28, 1'b0, -1, 1'b0, 10'h155);
        chk("t4_chan", {29'd0, conv_channel}, 32'd5);
        chk("t4_sgl", {31'd0, conv_sgl}, 32'd0);

        // 5: reset during MSB phase, frame must not resume
        d0 = done_cnt;
        frame(8'b11011, 5, 28, 1'b0, 9, 1'b0, 10'h2A5);
        chk("t5_done", done_cnt - d0, 32'd1);
        chk("t5_chan", {29'd0, conv_channel}, 32'd0);

        // 6: ch2 sample changes after capture
        sample_data[29:20] = 10'h100;
        d0 = done_cnt;
        frame(8'b11010, 5, 28, 1'b0, -1, 1'b1, 10'h100);
        chk("t6_chan", {29'd0, conv_channel}, 32'd2);
        chk("t6_done", done_cnt - d0, 32'd1);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
